// File: rtl/frame_pixel_streamer_if.sv
// Link between the frame pixel streamer and the feature extractor pixel port.
// master = streamer side, slave = extractor side.
interface frame_pixel_streamer_if;
    logic       start_out;
    logic       pix_valid_out;
    logic [7:0] pix_data_out;
    logic       res_valid_in;
    logic       done_in;

    modport master (
        output start_out,
        output pix_valid_out,
        output pix_data_out,
        input  res_valid_in,
        input  done_in
    );

    modport slave (
        input  start_out,
        input  pix_valid_out,
        input  pix_data_out,
        output res_valid_in,
        output done_in
    );
endinterface

// File: rtl/frame_pixel_streamer.sv
// Buffers one host-written frame and streams it in raster order to the feature extractor,
// then tracks its results/done. Define TEST_PATTERN_EN to emit an x^y pattern instead of memory.
module frame_pixel_streamer #(
    parameter int unsigned IMG_WIDTH    = 32,
    parameter int unsigned IMG_HEIGHT   = 32,
    parameter int unsigned EXP_RESULTS  = 225,
    parameter int unsigned DONE_TIMEOUT = 4096
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    wr_en,
    input  logic [$clog2(IMG_WIDTH*IMG_HEIGHT)-1:0] wr_addr,
    input  logic [7:0]                              wr_data,
    input  logic                                    go,
    input  logic                                    hold,
    frame_pixel_streamer_if.master                  ext,
    output logic                                    busy,
    output logic                                    frame_done,
    output logic [15:0]                             res_count,
    output logic                                    count_err,
    output logic                                    timeout_err
);
    localparam int unsigned NPIX = IMG_WIDTH * IMG_HEIGHT;
    localparam int unsigned AW   = $clog2(NPIX);
    localparam int unsigned CW   = $clog2(DONE_TIMEOUT + 1);

    typedef enum logic [2:0] {StIdle, StStart, StStream, StWaitDone, StFin} state_e;

    state_e        state;
    logic [AW-1:0] idx;
    logic [AW-1:0] rd_addr;
    logic [CW-1:0] wait_cnt;
    logic          done_seen;
    logic          start_q;
    logic [7:0]    pix_src;
    logic [7:0]    pix_last;
    logic          emit;
    logic          counting;
    logic          done_now;
    logic [15:0]   res_count_nxt;
    logic [7:0]    mem [NPIX];

    assign emit     = (state == StStream) && !hold;
    assign counting = state inside {StStart, StStream, StWaitDone};
    assign done_now = ext.done_in || done_seen;
    assign res_count_nxt = (counting && ext.res_valid_in && (res_count != 16'hFFFF)) ?
                           res_count + 16'd1 : res_count;

    // Read address runs one ahead while emitting so the registered read never bubbles.
    assign rd_addr = emit ? idx + AW'(1) : idx;

    assign ext.start_out     = start_q;
    assign ext.pix_valid_out = emit;
    assign ext.pix_data_out  = emit ? pix_src : pix_last;

    always_ff @(posedge clk) begin
        if (wr_en && (state == StIdle)) begin
            mem[wr_addr] <= wr_data;
        end
    end

`ifdef TEST_PATTERN_EN
    localparam int unsigned XW = $clog2(IMG_WIDTH);
    localparam int unsigned YW = $clog2(IMG_HEIGHT);

    logic [XW-1:0] pos_x;
    logic [YW-1:0] pos_y;

    always_ff @(posedge clk) begin
        if (rst || (state == StIdle)) begin
            pos_x <= '0;
            pos_y <= '0;
        end else if (emit) begin
            if (pos_x == XW'(IMG_WIDTH - 1)) begin
                pos_x <= '0;
                pos_y <= pos_y + YW'(1);
            end else begin
                pos_x <= pos_x + XW'(1);
            end
        end
    end

    assign pix_src = 8'(100) + (8'(pos_x) ^ 8'(pos_y));
`else
    logic [7:0] rd_data;

    always_ff @(posedge clk) begin
        rd_data <= mem[rd_addr];
    end

    assign pix_src = rd_data;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= StIdle;
            idx         <= '0;
            wait_cnt    <= '0;
            done_seen   <= 1'b0;
            start_q     <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            res_count   <= '0;
            count_err   <= 1'b0;
            timeout_err <= 1'b0;
            pix_last    <= '0;
        end else begin
            start_q    <= 1'b0;
            frame_done <= 1'b0;
            if (emit) begin
                pix_last <= pix_src;
            end
            if (state != StIdle) begin
                res_count <= res_count_nxt;
            end
            unique case (state)
                StIdle: begin
                    if (go) begin
                        state       <= StStart;
                        start_q     <= 1'b1;
                        busy        <= 1'b1;
                        idx         <= '0;
                        done_seen   <= 1'b0;
                        res_count   <= '0;
                        count_err   <= 1'b0;
                        timeout_err <= 1'b0;
                    end
                end
                StStart: begin
                    state <= StStream;
                    if (ext.done_in) begin
                        done_seen <= 1'b1;
                    end
                end
                StStream: begin
                    // An early done is remembered and honoured once streaming finishes.
                    if (ext.done_in) begin
                        done_seen <= 1'b1;
                    end
                    if (emit) begin
                        idx <= idx + AW'(1);
                        if (idx == AW'(NPIX - 1)) begin
                            state    <= StWaitDone;
                            wait_cnt <= '0;
                        end
                    end
                end
                StWaitDone: begin
                    if (done_now || (wait_cnt == CW'(DONE_TIMEOUT - 1))) begin
                        state       <= StFin;
                        frame_done  <= 1'b1;
                        timeout_err <= !done_now;
                        count_err   <= (res_count_nxt != 16'(EXP_RESULTS));
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                StFin: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_frame_pixel_streamer.sv
// Randomized self-checking bench for frame_pixel_streamer against a frame-level reference
// (expected pixel list, result tally and done/timeout deadlines).
module tb_frame_pixel_streamer;
    localparam int unsigned W    = 32;
    localparam int unsigned H    = 32;
    localparam int unsigned NPIX = W * H;
    localparam int unsigned EXP  = 225;
    localparam int unsigned TO   = 16;
    localparam int unsigned AW   = $clog2(NPIX);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [7:0]    wr_data = '0;
    logic          go = 1'b0;
    logic          hold = 1'b0;
    logic          busy;
    logic          frame_done;
    logic [15:0]   res_count;
    logic          count_err;
    logic          timeout_err;

    frame_pixel_streamer_if ext_if();

    frame_pixel_streamer #(
        .IMG_WIDTH   (W),
        .IMG_HEIGHT  (H),
        .EXP_RESULTS (EXP),
        .DONE_TIMEOUT(TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .go         (go),
        .hold       (hold),
        .ext        (ext_if),
        .busy       (busy),
        .frame_done (frame_done),
        .res_count  (res_count),
        .count_err  (count_err),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] ref_mem [NPIX];
    logic [7:0] last_pix = 8'd0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_pix(input int i);
`ifdef TEST_PATTERN_EN
        return 8'(100 + ((i % W) ^ (i / W)));
`else
        return ref_mem[i];
`endif
    endfunction

    task automatic load_mem(input bit rnd);
        for (int i = 0; i < NPIX; i++) begin
            @(posedge clk); #1;
            wr_en   = 1'b1;
            wr_addr = AW'(i);
            wr_data = rnd ? 8'($urandom) : 8'(i);
            ref_mem[i] = wr_data;
        end
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    // One frame: go, stream with optional holds/noise, extractor responses, completion checks.
    task automatic run_frame(input int n_res, input bit send_done, input bit early_done,
                             input int hold_at, input bit rnd, input int rst_at);
        int k, hold_left, res_left, tail, guard, w, exp_w, fd_seen;
        bit sent, rst_hit;
        tail      = early_done ? 0 : ((n_res < 2) ? n_res : 2);
        res_left  = n_res - tail;
        hold_left = 0;
        k         = 0;
        guard     = 0;
        rst_hit   = 1'b0;

        @(posedge clk); #1;
        go = 1'b1; hold = 1'b0; ext_if.res_valid_in = 1'b0; ext_if.done_in = 1'b0;
        #1;
        check_eq("idle_busy", busy, 0);
        @(posedge clk); #1;
        go = 1'b0;
        #1;
        check_eq("start_pulse", ext_if.start_out, 1);
        check_eq("start_busy", busy, 1);
        check_eq("go_clears_count", res_count, 0);
        check_eq("go_clears_count_err", count_err, 0);
        check_eq("go_clears_timeout_err", timeout_err, 0);
        check_eq("start_no_pixel", ext_if.pix_valid_out, 0);

        while (k < NPIX) begin
            @(posedge clk); #1;
            if (k == hold_at) begin
                hold_left = 3;
                hold_at   = -1;
            end
            hold = (hold_left > 0) || (rnd && ($urandom_range(7) == 0));
            if (hold_left > 0) hold_left--;
            ext_if.res_valid_in = (res_left > 0) && !hold &&
                                  (($urandom_range(1) == 0) || (res_left >= NPIX - k));
            if (ext_if.res_valid_in) res_left--;
            ext_if.done_in = early_done && (k == 700) && !hold;
            go      = rnd && ($urandom_range(15) == 0);
            wr_en   = rnd && ($urandom_range(7) == 0);
            wr_addr = AW'($urandom);
            wr_data = 8'($urandom);
            rst     = (k == rst_at) && !hold;
            #1;
            check_eq("stream_start_low", ext_if.start_out, 0);
            check_eq("stream_busy", busy, 1);
            check_eq("pix_valid", ext_if.pix_valid_out, !hold);
            if (!hold) begin
                check_eq($sformatf("pix_data[%0d]", k), ext_if.pix_data_out, exp_pix(k));
                last_pix = exp_pix(k);
                k++;
            end else begin
                check_eq("hold_data", ext_if.pix_data_out, last_pix);
            end
            if (rst) begin
                rst_hit = 1'b1;
                break;
            end
            guard++;
            if (guard > 4 * NPIX) begin
                check_eq("stream_bound", k, NPIX);
                break;
            end
        end

        if (rst_hit) begin
            @(posedge clk); #1;
            rst = 1'b0; go = 1'b0; wr_en = 1'b0; hold = 1'b0;
            ext_if.res_valid_in = 1'b0; ext_if.done_in = 1'b0;
            #1;
            last_pix = 8'd0;
            check_eq("rst_pix_valid", ext_if.pix_valid_out, 0);
            check_eq("rst_busy", busy, 0);
            check_eq("rst_res_count", res_count, 0);
            fd_seen = frame_done;
            repeat (20) begin
                @(posedge clk); #1; #1;
                fd_seen += frame_done;
            end
            check_eq("rst_no_frame_done", fd_seen, 0);
            return;
        end

        w       = 0;
        sent    = 1'b0;
        fd_seen = 0;
        exp_w   = early_done ? 1 : (send_done ? -1 : TO);
        while ((w < 40) && (fd_seen == 0)) begin
            @(posedge clk); #1;
            go = 1'b0; wr_en = 1'b0; hold = 1'($urandom_range(1));
            ext_if.res_valid_in = (tail > 0);
            if (tail > 0) tail--;
            ext_if.done_in = 1'b0;
            if (send_done && !early_done && (tail == 0) && !sent) begin
                ext_if.done_in = 1'b1;
                sent  = 1'b1;
                exp_w = w + 1;
            end
            #1;
            check_eq("wait_pix_valid", ext_if.pix_valid_out, 0);
            if (frame_done) begin
                fd_seen = 1;
                check_eq("frame_done_cycle", w, exp_w);
                check_eq("fin_res_count", res_count, n_res);
                check_eq("fin_count_err", count_err, (n_res != EXP));
                check_eq("fin_timeout_err", timeout_err, (!send_done && !early_done));
                check_eq("fin_busy", busy, 1);
            end
            w++;
        end
        check_eq("frame_done_seen", fd_seen, 1);

        @(posedge clk); #1;
        ext_if.res_valid_in = 1'b1; ext_if.done_in = 1'b0; hold = 1'b0;
        #1;
        check_eq("post_busy", busy, 0);
        check_eq("post_frame_done", frame_done, 0);
        @(posedge clk); #1;
        ext_if.res_valid_in = 1'b0;
        #1;
        check_eq("idle_res_count_hold", res_count, n_res);
        check_eq("idle_count_err_sticky", count_err, (n_res != EXP));
    endtask

    initial begin
        ext_if.res_valid_in = 1'b0;
        ext_if.done_in      = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_eq("rst_start", ext_if.start_out, 0);
        check_eq("rst_valid", ext_if.pix_valid_out, 0);
        check_eq("rst_data", ext_if.pix_data_out, 0);
        check_eq("rst_busy0", busy, 0);
        check_eq("rst_frame_done", frame_done, 0);
        check_eq("rst_count0", res_count, 0);
        check_eq("rst_count_err", count_err, 0);
        check_eq("rst_timeout_err", timeout_err, 0);

        load_mem(1'b0);
        run_frame(225, 1'b1, 1'b0, -1, 1'b0, -1);   // clean ramp frame
        run_frame(224, 1'b1, 1'b0, 40, 1'b0, -1);   // hold at 40, one result short
        load_mem(1'b1);
        run_frame(225, 1'b0, 1'b1, -1, 1'b1, -1);   // noisy inputs, done arrives mid-stream
        run_frame(225, 1'b0, 1'b0, -1, 1'b1, -1);   // extractor never finishes
        run_frame(225, 1'b1, 1'b0, -1, 1'b0, 500);  // reset mid-frame
        run_frame(225, 1'b1, 1'b0, -1, 1'b1, -1);   // restart after reset

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
